// File: rtl/lane_pkg.sv
// Shared types and default sizing for the lane combiner pipeline.
package lane_pkg;

  typedef enum logic [1:0] {
    MODE_AND = 2'd0,
    MODE_OR  = 2'd1,
    MODE_XOR = 2'd2,
    MODE_ADD = 2'd3
  } mode_e;

  localparam int unsigned NUM_CH_DEF = 4;
  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned CNT_W_DEF  = 16;

endpackage

// File: rtl/lane_op.sv
// Single-lane combinational operator: AND/OR/XOR/ADD with lane enable.
module lane_op
  import lane_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  mode_e            mode,
  input  logic             en,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  logic [WIDTH:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    if (en) begin
      unique case (mode)
        MODE_AND: res = a & b;
        MODE_OR:  res = a | b;
        MODE_XOR: res = a ^ b;
        MODE_ADD: begin
          res   = w_sum[WIDTH-1:0];
          carry = w_sum[WIDTH];
        end
        default: res = '0;
      endcase
    end
  end

endmodule

// File: rtl/lane_combine_pipe.sv
// Multi-lane operand combiner: capture stage S1, result stage S2, valid/ready on both sides.
module lane_combine_pipe
  import lane_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in1,
  input  logic [NUM_CH*WIDTH-1:0] in2,
  input  logic [1:0]              mode,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*WIDTH-1:0] out,
  output logic [NUM_CH-1:0]       out_carry,
  output logic [CNT_W-1:0]        beat_count
);

  localparam int unsigned DW = NUM_CH * WIDTH;

  logic              r_s1_valid;
  logic [DW-1:0]     r_s1_a;
  logic [DW-1:0]     r_s1_b;
  mode_e             r_s1_mode;
  logic [NUM_CH-1:0] r_s1_en;

  logic              r_s2_valid;
  logic [DW-1:0]     r_s2_res;
  logic [NUM_CH-1:0] r_s2_carry;
  logic [CNT_W-1:0]  r_beat_count;

  logic [DW-1:0]     w_res;
  logic [NUM_CH-1:0] w_carry;
  logic              w_deliver;
  logic              w_s2_load;
  logic              w_s1_load;
  logic              w_accept;

  // Each stage may load when it is empty or its content moves on this cycle.
  assign w_deliver = r_s2_valid && out_ready;
  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = rst_n && w_s1_load;
  assign w_accept  = in_valid && in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    lane_op #(.WIDTH(WIDTH)) u_lane_op (
      .a     (r_s1_a[k*WIDTH +: WIDTH]),
      .b     (r_s1_b[k*WIDTH +: WIDTH]),
      .mode  (r_s1_mode),
      .en    (r_s1_en[k]),
      .res   (w_res[k*WIDTH +: WIDTH]),
      .carry (w_carry[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_mode  <= MODE_AND;
      r_s1_en    <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a    <= in1;
        r_s1_b    <= in2;
        r_s1_mode <= mode_e'(mode);
        r_s1_en   <= ch_en;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
      r_s2_carry <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_res   <= w_res;
        r_s2_carry <= w_carry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_count <= '0;
    end else if (w_deliver) begin
      r_beat_count <= r_beat_count + CNT_W'(1);
    end
  end

  assign out_valid  = r_s2_valid;
  assign out        = r_s2_res;
  assign out_carry  = r_s2_carry;
  assign beat_count = r_beat_count;

endmodule

// File: tb/tb_lane_combine_pipe.sv
// Self-checking bench for lane_combine_pipe against a queue-based reference model.
module tb_lane_combine_pipe;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int CW  = 4;
  localparam int DW  = NCH * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in1;
  logic [DW-1:0] in2;
  logic [1:0]    mode;
  logic [NCH-1:0] ch_en;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out;
  logic [NCH-1:0] out_carry;
  logic [CW-1:0] beat_count;

  always #5 clk = ~clk;

  lane_combine_pipe #(.NUM_CH(NCH), .WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .mode       (mode),
    .ch_en      (ch_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .out_carry  (out_carry),
    .beat_count (beat_count)
  );

  typedef struct {
    logic [DW-1:0]  res;
    logic [NCH-1:0] carry;
    int             cyc;
  } beat_t;

  beat_t          q[$];
  int             now = 0;
  int             n_checks = 0;
  int             n_fail = 0;
  int             exp_cnt = 0;
  bit             prev_stall = 0;
  bit             last_acc = 0;
  logic [DW-1:0]  stall_out;
  logic [NCH-1:0] stall_carry;

  // Lane-by-lane result from the operation definitions, using plain integers.
  function automatic beat_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [1:0] m, input logic [NCH-1:0] en);
    beat_t r;
    r.res   = '0;
    r.carry = '0;
    r.cyc   = 0;
    for (int k = 0; k < NCH; k++) begin
      int x, y, v;
      x = int'(a[k*W +: W]);
      y = int'(b[k*W +: W]);
      case (m)
        2'd0:    v = x & y;
        2'd1:    v = x | y;
        2'd2:    v = x ^ y;
        default: v = x + y;
      endcase
      if (!en[k]) v = 0;
      r.res[k*W +: W] = W'(v % 256);
      r.carry[k]      = (m == 2'd3) && (v >= 256);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_rand();
    in1   = $urandom;
    in2   = $urandom;
    mode  = 2'($urandom_range(0, 3));
    ch_en = 4'($urandom_range(0, 15));
  endtask

  task automatic cycle();
    beat_t e;
    bit    exp_ov;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(rst_n && (q.size() < 2 || out_ready)));
    exp_ov = (q.size() > 0) && (q[0].cyc + 1 < now);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out", out, q[0].res);
      chk("out_carry", 32'(out_carry), 32'(q[0].carry));
    end
    if (prev_stall) begin
      chk("stall_out", out, stall_out);
      chk("stall_carry", 32'(out_carry), 32'(stall_carry));
    end
    chk("beat_count", 32'(beat_count), 32'(exp_cnt % 16));
    prev_stall  = out_valid && !out_ready;
    stall_out   = out;
    stall_carry = out_carry;
    last_acc    = in_valid && in_ready;
    if (out_valid && out_ready && q.size() > 0) begin
      void'(q.pop_front());
      exp_cnt++;
    end
    if (last_acc) begin
      e = model(in1, in2, mode, ch_en);
      e.cyc = now;
      q.push_back(e);
    end
    @(posedge clk);
    now++;
    #1;
  endtask

  task automatic clear_model();
    q.delete();
    exp_cnt    = 0;
    prev_stall = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, ov_cycles, guard, cnt0;
    bit dropped;

    // Reset with a beat offered.
    rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in1 = '0; in2 = '0; mode = 2'd0; ch_en = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_out_carry", 32'(out_carry), 32'd0);
    chk("rst_beat_count", 32'(beat_count), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    clear_model();
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    now++;
    #1;

    // Directed ADD beat.
    in_valid = 1'b1; mode = 2'd3; ch_en = 4'hF;
    in1 = 32'h801001FF; in2 = 32'h80200101;
    cycle();
    in_valid = 1'b0;
    drive_rand();
    cycle();
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_out", out, 32'h00300200);
    chk("add_carry", 32'(out_carry), 32'h9);

    // Directed XOR beat with partial lane enable.
    in_valid = 1'b1; mode = 2'd2; ch_en = 4'b0101;
    in1 = 32'hAAAAAAAA; in2 = 32'h55555555;
    cycle();
    in_valid = 1'b0;
    drive_rand();
    cycle();
    chk("xor_out", out, 32'h00FF00FF);
    chk("xor_carry", 32'(out_carry), 32'h0);
    cycle();

    // Backpressure: five back-to-back beats, consumer stalls three cycles.
    cnt0 = exp_cnt; acc = 0; ov_cycles = 0; guard = 0; dropped = 0;
    out_ready = 1'b0;
    while (exp_cnt - cnt0 < 5 && guard < 40) begin
      in_valid  = (acc < 5);
      out_ready = (ov_cycles >= 3);
      drive_rand();
      cycle();
      if (last_acc) acc++;
      if (out_valid && !out_ready) ov_cycles++;
      if (!in_ready && !dropped) begin
        dropped = 1;
        chk("bp_accepts_at_full", acc, 32'd2);
      end
      guard++;
    end
    chk("bp_delivered", exp_cnt - cnt0, 32'd5);
    chk("bp_saw_full", 32'(dropped), 32'd1);
    chk("bp_count_delta", 32'(CW'(beat_count - CW'(cnt0))), 32'd5);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    // Mid-flight reset with two beats in the pipe.
    out_ready = 1'b0;
    in_valid = 1'b1; drive_rand(); cycle();
    drive_rand(); cycle();
    in_valid = 1'b0;
    chk("mid_full_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(beat_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b1;
    clear_model();
    out_ready = 1'b1;
    repeat (4) cycle();

    // Counter wrap: 17 deliveries on a 4-bit counter.
    guard = 0; acc = 0;
    while (exp_cnt < 17 && guard < 60) begin
      in_valid = (acc < 17);
      drive_rand();
      cycle();
      if (last_acc) acc++;
      guard++;
    end
    chk("wrap_delivered", exp_cnt, 32'd17);
    chk("wrap_count", 32'(beat_count), 32'd1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive_rand();
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      cycle();
      guard++;
    end
    chk("drain_empty", q.size(), 32'd0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_combine_pipe.md
# lane_combine_pipe

Parametrised multi-channel operand combiner: NUM_CH independent lanes each combine two WIDTH-bit operands under a per-beat mode, with a two-stage registered pipeline and valid/ready handshakes on both sides. It is the next generation of the single-lane two-input/one-output building block: wider, multi-channel, mode-selectable, and flow-controlled. It sits between a producer and consumer stream and sustains one beat per cycle.

## Interface
- NUM_CH, 4: number of lanes; lane k occupies bits [k*WIDTH +: WIDTH].
- WIDTH, 8: operand and result width per lane.
- CNT_W, 16: width of the delivered-beat counter.
- clk  in  1  rising-edge clock; the block uses only this clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in1  in  NUM_CH*WIDTH  operand A, all lanes.
- in2  in  NUM_CH*WIDTH  operand B, all lanes.
- mode  in  2  operation for this beat: 0 AND, 1 OR, 2 XOR, 3 ADD.
- ch_en  in  NUM_CH  lane enable for this beat; a disabled lane yields result 0 and carry 0.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- out  out  NUM_CH*WIDTH  per-lane results.
- out_carry  out  NUM_CH  per-lane carry-out. It is valid in ADD only and is 0 in other modes.
- beat_count  out  CNT_W  count of delivered beats (out_valid && out_ready). It wraps modulo 2^CNT_W.

## Operation
- Accept: in_valid && in_ready. Capture in1, in2, mode and ch_en together into stage 1 (S1).
- S1 → S2: lane results are computed from S1 registers and registered into S2.
  - ADD result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the sum.
- Delivery: S2 drives out, out_carry, out_valid. A beat leaves on out_valid && out_ready.
- Advance rules:
  - S2 loads when S2 is empty or is delivering this cycle.
  - S1 loads when S1 is empty or S1 advances into S2.
  - Bubbles collapse.
- in_ready = rst_n && (!s1_valid || !s2_valid || out_ready).
- Stall: while out_valid && !out_ready, out, out_carry and out_valid hold stable.
- Ordering: beats exit in acceptance order. No beat is dropped or duplicated.
- beat_count increments by 1 on each delivery and wraps from 2^CNT_W−1 to 0.
- Reset asserted at any time, including mid-stream:
  - s1_valid, s2_valid, all data registers and beat_count clear immediately (asynchronously).
  - In-flight beats are discarded. Nothing emerges after release.

## Timing
- Reset values: out_valid 0, out 0, out_carry 0, beat_count 0. in_ready is 0 while rst_n is low and 1 in the first cycle after release.
- Latency: a beat accepted at edge N presents out_valid after edge N+1. It can be delivered at edge N+2.
- Throughput: 1 beat/cycle with out_ready held high.
- Capacity: 2 beats. With out_ready low, in_ready falls after 2 accepts.
- Combinational paths:
  - out_ready → in_ready: permitted.
  - in_valid or data → any output: none.
- Simultaneous accept and deliver on a full pipe is legal. All stages shift in the same cycle.
- mode and ch_en matter only on the accept cycle. Changes at other times have no effect.

## Structure
- Package lane_pkg:
  - mode_e typedef (MODE_AND=0, MODE_OR=1, MODE_XOR=2, MODE_ADD=3).
  - Default parameter constants.
- Sub-module lane_op (combinational):
  - Inputs: a, b (WIDTH), mode_e mode, en.
  - Outputs: res (WIDTH), carry.
  - Instantiated NUM_CH times in a generate loop, with ports connected by name.
- Top level holds the S1/S2 registers, handshake logic and counter.

## Test plan
- Reset: hold rst_n low with in_valid=1 → in_ready=0, out_valid=0, out=0, beat_count=0. Release → in_ready=1 the next cycle.
- ADD beat (defaults):
  - Stimulus: in1 lanes {0x80,0x10,0x01,0xFF}, in2 {0x80,0x20,0x01,0x01} (lane3..0), ch_en=4'hF.
  - Response two cycles later: out lanes {0x00,0x30,0x02,0x00}, out_carry=4'b1001.
- XOR with ch_en=4'b0101, all in1 lanes 0xAA, all in2 lanes 0x55 → lanes 0 and 2 = 0xFF, lanes 1 and 3 = 0x00, out_carry=0.
- Backpressure:
  - Stimulus: offer 5 beats back-to-back; hold out_ready low for 3 cycles after the first out_valid.
  - Response: in_ready drops after 2 accepts; out holds stable; all 5 beats arrive in order; beat_count=5.
- Mid-flight reset: 2 beats in flight, pulse rst_n low between edges → out_valid drops immediately; no beat appears after release; beat_count=0.
- Counter wrap with CNT_W=4: deliver 17 beats → beat_count=1.
